// File: rtl/bcd_stopwatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_if
//  Description : Bundle of the stopwatch control inputs and display outputs.
//                master = the side that drives the timebase and buttons and
//                         reads the digits (board glue or testbench).
//                slave  = the stopwatch core.
//  Signals     : tick_in    - divided clock from the divider stage (async level)
//                start_stop - debounced run/pause button
//                clear      - debounced clear button
//                lap        - debounced lap button
//                sec_ones, sec_tens, min_ones, min_tens - BCD digits
//                running    - stopwatch is counting
//                wrap       - one-cycle pulse on 59:59 -> 00:00
//                lap_hold   - display is frozen on the lap register
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_stopwatch_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       wrap;
  logic       lap_hold;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens, running, wrap, lap_hold
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens, running, wrap, lap_hold
  );
endinterface
`default_nettype wire

// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch
//  Description : MM:SS stopwatch driven by an asynchronous divided-clock
//                timebase. Rising edges of tick_in are synchronised, optionally
//                prescaled, and advance a four-digit BCD count that wraps at
//                59:59. Run/pause/clear control via debounced buttons.
//  Parameters  : SYNC_STAGES     - tick_in synchroniser depth (2..4)
//                TICKS_PER_COUNT - tick_in edges per count increment (1..1023)
//  Ports       : clk - system clock, rising edge
//                rst - asynchronous reset, active low
//                sw  - bcd_stopwatch_if.slave (timebase, buttons, display)
//  Options     : BCD_STOPWATCH_LAP_EN - when defined, the lap button freezes
//                the display on a captured lap value while the count runs on.
//                When undefined, lap is ignored and lap_hold is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch #(
  parameter int SYNC_STAGES     = 2,
  parameter int TICKS_PER_COUNT = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_stopwatch_if.slave sw
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_PAUSE = 2'd2;

  localparam logic [9:0] c_PRESCALE_LAST = 10'(TICKS_PER_COUNT - 1);

  // --------------------------------------------------------------------------
  // Timebase synchroniser and rising-edge detector
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_tick_sync;
  logic                   r_tick_prev;
  logic                   w_tick_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_sync <= '0;
      r_tick_prev <= 1'b0;
    end else begin
      r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], sw.tick_in};
      r_tick_prev <= r_tick_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick_edge = r_tick_sync[SYNC_STAGES-1] & ~r_tick_prev;

  // --------------------------------------------------------------------------
  // Button edge detectors: one capture register plus one history register,
  // so a held button yields a single edge.
  // --------------------------------------------------------------------------
  logic r_ss_q;
  logic r_ss_prev;
  logic r_clr_q;
  logic r_clr_prev;
  logic w_ss_edge;
  logic w_clr_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ss_q     <= 1'b0;
      r_ss_prev  <= 1'b0;
      r_clr_q    <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_ss_q     <= sw.start_stop;
      r_ss_prev  <= r_ss_q;
      r_clr_q    <= sw.clear;
      r_clr_prev <= r_clr_q;
    end
  end

  assign w_ss_edge  = r_ss_q & ~r_ss_prev;
  assign w_clr_edge = r_clr_q & ~r_clr_prev;

  // --------------------------------------------------------------------------
  // Control FSM: state register / next-state logic / output logic
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_running;
  logic       w_running_next;
  logic       w_count_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear outranks start_stop; both outrank the timebase.
  always_comb begin
    w_state_next = r_state;
    if (w_clr_edge) begin
      w_state_next = c_ST_IDLE;
    end else if (w_ss_edge) begin
      case (r_state)
        c_ST_IDLE:  w_state_next = c_ST_RUN;
        c_ST_RUN:   w_state_next = c_ST_PAUSE;
        c_ST_PAUSE: w_state_next = c_ST_RUN;
        default:    w_state_next = c_ST_IDLE;
      endcase
    end
  end

  // A tick is only honoured in RUN and only when no button edge lands in the
  // same cycle; a tick arriving alongside a pause or resume is dropped.
  always_comb begin
    w_running_next = (w_state_next == c_ST_RUN);
    w_count_en     = (r_state == c_ST_RUN) & w_tick_edge & ~w_clr_edge & ~w_ss_edge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running <= 1'b0;
    end else begin
      r_running <= w_running_next;
    end
  end

  // --------------------------------------------------------------------------
  // Tick prescaler
  // --------------------------------------------------------------------------
  logic [9:0] r_prescale;
  logic       w_inc;

  assign w_inc = w_count_en & (r_prescale == c_PRESCALE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= 10'd0;
    end else if (w_clr_edge) begin
      r_prescale <= 10'd0;
    end else if (w_count_en) begin
      if (r_prescale == c_PRESCALE_LAST) begin
        r_prescale <= 10'd0;
      end else begin
        r_prescale <= r_prescale + 10'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // BCD count cascade. Digits only ever step from a legal value, so they can
  // never leave their BCD ranges.
  // --------------------------------------------------------------------------
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic       r_wrap;
  logic       w_so_max;
  logic       w_st_max;
  logic       w_mo_max;
  logic       w_mt_max;

  assign w_so_max = (r_sec_ones == 4'd9);
  assign w_st_max = (r_sec_tens == 4'd5);
  assign w_mo_max = (r_min_ones == 4'd9);
  assign w_mt_max = (r_min_tens == 4'd5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
    end else if (w_clr_edge) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
    end else if (w_inc) begin
      if (!w_so_max) begin
        r_sec_ones <= r_sec_ones + 4'd1;
      end else begin
        r_sec_ones <= 4'd0;
        if (!w_st_max) begin
          r_sec_tens <= r_sec_tens + 4'd1;
        end else begin
          r_sec_tens <= 4'd0;
          if (!w_mo_max) begin
            r_min_ones <= r_min_ones + 4'd1;
          end else begin
            r_min_ones <= 4'd0;
            if (!w_mt_max) begin
              r_min_tens <= r_min_tens + 4'd1;
            end else begin
              r_min_tens <= 4'd0;
            end
          end
        end
      end
    end
  end

  // Pulses on the same edge the digits roll to 00:00, drops on the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_inc & w_so_max & w_st_max & w_mo_max & w_mt_max;
    end
  end

  assign sw.running = r_running;
  assign sw.wrap    = r_wrap;

  // --------------------------------------------------------------------------
  // Lap freeze
  // --------------------------------------------------------------------------
`ifdef BCD_STOPWATCH_LAP_EN
  logic       r_lap_q;
  logic       r_lap_prev;
  logic       w_lap_edge;
  logic       r_lap_hold;
  logic [3:0] r_lap_sec_ones;
  logic [3:0] r_lap_sec_tens;
  logic [3:0] r_lap_min_ones;
  logic [3:0] r_lap_min_tens;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lap_q    <= 1'b0;
      r_lap_prev <= 1'b0;
    end else begin
      r_lap_q    <= sw.lap;
      r_lap_prev <= r_lap_q;
    end
  end

  assign w_lap_edge = r_lap_q & ~r_lap_prev;

  // First lap edge snapshots the live count (value before any increment in
  // the same cycle); the next lap edge releases the display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lap_hold     <= 1'b0;
      r_lap_sec_ones <= 4'd0;
      r_lap_sec_tens <= 4'd0;
      r_lap_min_ones <= 4'd0;
      r_lap_min_tens <= 4'd0;
    end else if (w_clr_edge) begin
      r_lap_hold <= 1'b0;
    end else if (w_lap_edge && (r_state != c_ST_IDLE)) begin
      if (r_lap_hold) begin
        r_lap_hold <= 1'b0;
      end else begin
        r_lap_hold     <= 1'b1;
        r_lap_sec_ones <= r_sec_ones;
        r_lap_sec_tens <= r_sec_tens;
        r_lap_min_ones <= r_min_ones;
        r_lap_min_tens <= r_min_tens;
      end
    end
  end

  assign sw.sec_ones = r_lap_hold ? r_lap_sec_ones : r_sec_ones;
  assign sw.sec_tens = r_lap_hold ? r_lap_sec_tens : r_sec_tens;
  assign sw.min_ones = r_lap_hold ? r_lap_min_ones : r_min_ones;
  assign sw.min_tens = r_lap_hold ? r_lap_min_tens : r_min_tens;
  assign sw.lap_hold = r_lap_hold;
`else
  logic w_lap_unused;

  assign w_lap_unused = sw.lap;
  assign sw.sec_ones  = r_sec_ones;
  assign sw.sec_tens  = r_sec_tens;
  assign sw.min_ones  = r_min_ones;
  assign sw.min_tens  = r_min_tens;
  assign sw.lap_hold  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch
//  Description : Scoreboard bench for bcd_stopwatch. dut0 uses SYNC_STAGES=2,
//                TICKS_PER_COUNT=1; dut1 uses SYNC_STAGES=3,
//                TICKS_PER_COUNT=5. Expected display words are queued by the
//                stimulus and compared by an independent monitor.
//                Expectations follow BCD_STOPWATCH_LAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch;

`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    localparam int c_TIMEOUT = 2000000;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [1:0] tk = 2'b00;
    logic [1:0] ss = 2'b00;
    logic [1:0] clr = 2'b00;
    logic [1:0] lp = 2'b00;
    bit         done = 1'b0;

    always #5 clk = ~clk;

    bcd_stopwatch_if if0 ();
    bcd_stopwatch_if if1 ();

    assign if0.tick_in    = tk[0];
    assign if0.start_stop = ss[0];
    assign if0.clear      = clr[0];
    assign if0.lap        = lp[0];
    assign if1.tick_in    = tk[1];
    assign if1.start_stop = ss[1];
    assign if1.clear      = clr[1];
    assign if1.lap        = lp[1];

    bcd_stopwatch #(.SYNC_STAGES(2), .TICKS_PER_COUNT(1)) u_dut0 (
        .clk (clk),
        .rst (rst_n[0]),
        .sw  (if0.slave)
    );

    bcd_stopwatch #(.SYNC_STAGES(3), .TICKS_PER_COUNT(5)) u_dut1 (
        .clk (clk),
        .rst (rst_n[1]),
        .sw  (if1.slave)
    );

    logic [18:0] g0;
    logic [18:0] g1;
    assign g0 = {if0.running, if0.wrap, if0.lap_hold,
                 if0.min_tens, if0.min_ones, if0.sec_tens, if0.sec_ones};
    assign g1 = {if1.running, if1.wrap, if1.lap_hold,
                 if1.min_tens, if1.min_ones, if1.sec_tens, if1.sec_ones};

    typedef struct {
        int          d;
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [18:0] ev(input int m, input int s,
                                       input bit run, input bit wr, input bit lh);
        return {run, wr, lh, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // ---------------- monitor ----------------
    exp_t        mon_e;
    logic [18:0] mon_got;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_got = (mon_e.d == 0) ? g0 : g1;
            checks++;
            if (mon_got !== mon_e.v) begin
                errors++;
                $display("FAIL %s dut%0d got %h expected %h", mon_e.name, mon_e.d, mon_got, mon_e.v);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #c_TIMEOUT;
        if (!done) begin
            errors++;
            $display("FAIL timeout: test sequence did not complete");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input int d, input string name, input int m, input int s,
                            input bit run, input bit wr, input bit lh);
        exp_t e;
        e.d    = d;
        e.name = name;
        e.v    = ev(m, s, run, wr, lh);
        sb.push_back(e);
    endtask

    task automatic chk(input int d, input string name, input int m, input int s,
                       input bit run, input bit lh);
        @(posedge clk);
        #1;
        push_exp(d, name, m, s, run, 1'b0, lh);
        @(negedge clk);
    endtask

    task automatic tick(input int d, input int sel);
        @(negedge clk);
        tk[d] = 1'b1;
        @(negedge clk);
        case (sel)
            1:       clr[d] = 1'b1;
            2:       ss[d]  = 1'b1;
            3:       lp[d]  = 1'b1;
            default: ;
        endcase
        @(negedge clk);
        clr[d] = 1'b0;
        ss[d]  = 1'b0;
        lp[d]  = 1'b0;
        repeat (2) @(negedge clk);
        tk[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ticks(input int d, input int n);
        for (int i = 0; i < n; i++) tick(d, 0);
    endtask

    task automatic pulse(input int d, input int sel);
        @(negedge clk);
        case (sel)
            1:       clr[d] = 1'b1;
            2:       ss[d]  = 1'b1;
            3:       lp[d]  = 1'b1;
            default: ;
        endcase
        @(negedge clk);
        clr[d] = 1'b0;
        ss[d]  = 1'b0;
        lp[d]  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_trace(input string name, input int m0, input int s0,
                              input int m1, input int s1, input bit wr);
        @(negedge clk);
        tk[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        push_exp(0, {name, "_k1"}, m0, s0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push_exp(0, {name, "_k2"}, m1, s1, 1'b1, wr, 1'b0);
        @(posedge clk);
        #1;
        push_exp(0, {name, "_k3"}, m1, s1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tk[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ((g0 !== ev(0, 0, 1'b0, 1'b0, 1'b0)) || (g1 !== ev(0, 0, 1'b0, 1'b0, 1'b0))) begin
            errors++;
            $display("FAIL reset_state got %h / %h expected all zero", g0, g1);
        end
        push_exp(0, "reset0", 0, 0, 1'b0, 1'b0, 1'b0);
        push_exp(1, "reset1", 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 2'b11;

        pulse(0, 2);
        chk(0, "start", 0, 0, 1'b1, 1'b0);
        tick_trace("latency", 0, 0, 0, 1, 1'b0);
        ticks(0, 11);
        chk(0, "run12", 0, 12, 1'b1, 1'b0);
        pulse(0, 1);
        chk(0, "clear", 0, 0, 1'b0, 1'b0);

        pulse(0, 2);
        ticks(0, 5);
        chk(0, "run5", 0, 5, 1'b1, 1'b0);
        pulse(0, 2);
        chk(0, "pause", 0, 5, 1'b0, 1'b0);
        ticks(0, 3);
        chk(0, "pause_ticks", 0, 5, 1'b0, 1'b0);
        pulse(0, 2);
        tick(0, 0);
        chk(0, "resume", 0, 6, 1'b1, 1'b0);

        ticks(0, 53);
        chk(0, "s59", 0, 59, 1'b1, 1'b0);
        tick(0, 0);
        chk(0, "m01", 1, 0, 1'b1, 1'b0);
        ticks(0, 3539);
        chk(0, "m59s59", 59, 59, 1'b1, 1'b0);
        tick_trace("wrap", 59, 59, 0, 0, 1'b1);

        ticks(0, 7);
        chk(0, "s07", 0, 7, 1'b1, 1'b0);
        tick(0, 1);
        chk(0, "clear_tick", 0, 0, 1'b0, 1'b0);
        pulse(0, 2);
        ticks(0, 3);
        chk(0, "s03", 0, 3, 1'b1, 1'b0);
        tick(0, 2);
        chk(0, "pause_tick", 0, 3, 1'b0, 1'b0);
        tick(0, 2);
        chk(0, "resume_tick", 0, 3, 1'b1, 1'b0);
        tick(0, 0);
        chk(0, "s04", 0, 4, 1'b1, 1'b0);

        pulse(0, 3);
        chk(0, "lap_on", 0, 4, 1'b1, LAP);
        ticks(0, 6);
        chk(0, "lap_frozen", 0, LAP ? 4 : 10, 1'b1, LAP);
        pulse(0, 3);
        chk(0, "lap_off", 0, 10, 1'b1, 1'b0);
        pulse(0, 3);
        chk(0, "lap_again", 0, 10, 1'b1, LAP);
        pulse(0, 1);
        chk(0, "lap_clear", 0, 0, 1'b0, 1'b0);
        pulse(0, 3);
        chk(0, "lap_idle", 0, 0, 1'b0, 1'b0);

        pulse(0, 2);
        ticks(0, 2);
        chk(0, "s02", 0, 2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        #1;
        push_exp(0, "async_rst", 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        tick(0, 0);
        chk(0, "post_rst_tick", 0, 0, 1'b0, 1'b0);

        pulse(1, 2);
        ticks(1, 14);
        chk(1, "pre14", 0, 2, 1'b1, 1'b0);
        pulse(1, 2);
        ticks(1, 4);
        chk(1, "pre_pause", 0, 2, 1'b0, 1'b0);
        pulse(1, 2);
        tick(1, 0);
        chk(1, "pre_resume", 0, 3, 1'b1, 1'b0);
        ticks(1, 4);
        chk(1, "pre_hold", 0, 3, 1'b1, 1'b0);
        tick(1, 0);
        chk(1, "pre_next", 0, 4, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Single-clock MM:SS stopwatch that consumes the divided clock produced by the clock divider stage. It treats that signal as a timebase, detects its rising edges, and advances a four-digit BCD count. It has run/pause/clear control and wrap-around at 59:59. The outputs drive the board's seven-segment decoder stage directly.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `tick_in` synchronizer; legal range 2..4.
- `TICKS_PER_COUNT`, 1: `tick_in` rising edges per count increment; legal range 1..1023.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset).
- `tick_in` input 1: divided clock from the divider stage; treated as asynchronous level.
- `start_stop` input 1: synchronous, debounced; a rising edge toggles run/pause.
- `clear` input 1: synchronous, debounced; a rising edge zeroes the count.
- `lap` input 1: synchronous, debounced; a rising edge toggles lap freeze (see Configuration).
- `sec_ones` output 4: BCD 0..9.
- `sec_tens` output 4: BCD 0..5.
- `min_ones` output 4: BCD 0..9.
- `min_tens` output 4: BCD 0..5.
- `running` output 1: high in the RUN state.
- `wrap` output 1: one-cycle pulse when the count rolls 59:59 -> 00:00.
- `lap_hold` output 1: high while the display is frozen.

## Operation
- States:
  - IDLE (count 00:00, stopped).
  - RUN.
  - PAUSE.
- Transitions:
  - IDLE + start_stop edge -> RUN.
  - RUN + start_stop edge -> PAUSE.
  - PAUSE + start_stop edge -> RUN.
  - Any state + clear edge -> IDLE.
- Edge detection: each control input is registered once, and edge = cur & ~prev. A level held high produces exactly one edge.
- tick_in passes through the `SYNC_STAGES` flip-flop chain, then edge detection against the last stage.
- Tick prescaler: a 10-bit counter.
  - Increments on each tick edge in RUN.
  - On reaching `TICKS_PER_COUNT`-1 with another tick edge, it returns to 0 and issues an increment.
  - Holds its value in PAUSE. Zeroed by clear and by reset.
- Increment cascade, all updated in one clock edge:
  - sec_ones 9 -> 0 carries to sec_tens.
  - sec_tens 5 -> 0 carries to min_ones.
  - min_ones 9 -> 0 carries to min_tens.
  - min_tens 5 -> 0 marks the wrap.
- Wrap: 59:59 -> 00:00, `wrap` high for exactly one clk cycle, state stays RUN.
- Tick edges in IDLE or PAUSE are discarded. They are not queued.
- Priority when events coincide in one cycle: clear > start_stop > tick.
  - Clear + tick: count = 00:00, no increment.
  - Start_stop (RUN->PAUSE) + tick: the increment is suppressed.
  - Start_stop (PAUSE->RUN) + tick: that tick is not counted.
- Internal count digits never leave their BCD ranges. There is no illegal-value path.

## Timing
- Reset (`rst` = 0), immediate and asynchronous:
  - All digits 0, `running` 0, `wrap` 0, `lap_hold` 0.
  - State IDLE, synchronizer and edge registers 0, prescaler 0.
- tick_in latency: if tick_in rises before clk edge k, the count updates at edge k+`SYNC_STAGES` (edge k+2 at default).
- Control latency: if start_stop/clear/lap rises before edge k, edge detection fires in the cycle after k. State and outputs change at edge k+1.
- `running` is a registered decode of the state and changes on the same edge as the state.
- `wrap` asserts on the edge where the digits become 00:00 and deasserts on the next edge.
- Reset mid-count: outputs are 0 asynchronously. After release, the first tick edge counts only if RUN has been re-entered.
- Minimum tick_in high and low time: `SYNC_STAGES`+1 clk periods. Shorter pulses may be lost.

## Configuration
- Macro `BCD_STOPWATCH_LAP_EN`.
- Defined:
  - A lap edge in RUN or PAUSE copies the live count into a lap register and sets `lap_hold` = 1. The digit outputs then show the lap register.
  - The internal count keeps running.
  - A second lap edge clears `lap_hold`, and the outputs show the live count from the next cycle.
  - Clear or reset also clears `lap_hold`.
  - A lap edge in IDLE is ignored.
  - `wrap` always reflects the live count.
- Undefined:
  - The `lap` port exists but is ignored.
  - `lap_hold` is tied 0 and the digits always show the live count.
  - No lap register is synthesized.

## Test plan
- Reset and run: assert rst=0, release, pulse start_stop, apply 12 tick_in edges (`TICKS_PER_COUNT`=1) -> digits 00:12, `running`=1; tick at edge k updates at edge k+2.
- Pause: run to 00:05, start_stop edge, apply 3 ticks -> digits stay 00:05, `running`=0; resume, 1 tick -> 00:06.
- Rollover: run to 00:59, 1 tick -> 01:00. Run to 59:59, 1 tick -> 00:00, `wrap` high exactly 1 cycle, `running` stays 1.
- Priority: clear and a tick edge in the same cycle at 00:07 -> 00:00, state IDLE. Start_stop (RUN->PAUSE) coincident with a tick at 00:03 -> 00:03.
- Prescaler: `TICKS_PER_COUNT`=5, 14 ticks -> 00:02. Pause, 4 ticks, resume, 1 tick -> 00:03.
- Lap (macro defined): lap at 00:04, 6 more ticks -> outputs 00:04, `lap_hold`=1; second lap -> 00:10 next cycle. Macro undefined: same stimulus shows 00:10 throughout and `lap_hold`=0.
